counter32_sched: RTL and testbench
==================================

Name: counter32_sched

Overview:
- Scheduler that time-shares one 32-bit preset/down-count timer (Preset/PresetVal/Zero interface, decrements every clock when not preset) between NumReq requesters.
- Each requester asks for a delay of N cycles. The block grants the requesters round-robin, presets the timer with the granted delay, waits for Zero, then returns a one-cycle Done pulse to that requester.
- Sits between software/FSM requesters in the reconfigurable module and a single shared Counter32 timer instance.

Parameters:
- NumReq, 4, number of requesters; legal range 2..8.

Ports:
- Clk_i  in  1  clock; all logic on posedge.
- Reset_n_i  in  1  asynchronous active-low reset (fixed: one clock, async active-low reset).
- Req_i  in  NumReq  level request per requester; held high until Done_o is seen.
- Delay_i  in  32*NumReq  packed delays; requester k uses bits [32k+31:32k].
- Grant_o  out  NumReq  one-hot; the requester currently owning the timer.
- Done_o  out  NumReq  one-cycle pulse to the granted requester on expiry.
- Busy_o  out  1  high whenever state is not IDLE.
- Preset_o  out  1  preset strobe to the timer.
- PresetVal_o  out  32  preset value to the timer.
- Zero_i  in  1  timer zero flag; combinational function of the timer register.

Behaviour:
- States:
  - IDLE, LOAD, WAIT, DONE, held in a registered state variable.
  - Round-robin pointer RR (log2 NumReq bits) selects the highest-priority requester.
- Reset (async, at any time including mid-WAIT):
  - State=IDLE, Grant_o=0, Done_o=0, RR=0.
  - Preset_o=0, PresetVal_o=0.
  - Busy_o=0.
- IDLE:
  - If any Req_i is high, pick the first high bit searching upward from RR with wrap.
  - Register the picked requester as g, set Grant_o[g], go to LOAD.
  - Set RR=(g+1) mod NumReq.
  - If no Req_i is high, stay in IDLE.
- LOAD (exactly one cycle):
  - Preset_o=1; PresetVal_o=Delay_i[g] (combinational from the granted slice).
  - Go to WAIT.
- WAIT:
  - Preset_o=0. The timer holds V in the first WAIT cycle and decrements each cycle.
  - When Zero_i=1, go to DONE.
  - Zero_i is ignored in every state except WAIT.
- DONE (exactly one cycle):
  - Done_o[g]=1 and Grant_o[g] still high.
  - Req_i[g] is ignored in this cycle. Go to IDLE.
  - In IDLE, Grant_o=0 and Done_o=0.
- Timing for delay V with Req_i[g] rising in cycle 0 while the block is idle:
  - Cycle 1: LOAD.
  - Cycles 2..2+V: WAIT.
  - Cycle 3+V: Done_o[g].
  - Cycle 4+V: IDLE, block can accept the next request.
- Delay edge values:
  - V=0: Done_o in cycle 3.
  - V=0xFFFFFFFF: legal, no saturation or special case.
- Handshake:
  - The requester drops Req_i no later than the cycle after Done_o.
  - If Req_i is still high in IDLE, it counts as a new request.
- Abort:
  - If Req_i[g] is low in LOAD or WAIT, the next state is IDLE.
  - No Done_o is issued and Grant_o clears.
  - RR has already advanced.
- Changing Delay_i[g] after LOAD has no effect on a running count.
- Output registration:
  - Done_o, Grant_o and state are registered.
  - Preset_o and PresetVal_o are decoded from state and g.

Optional Feature:
- Macro COUNTER32_SCHED_PARK_EN.
- Defined:
  - In IDLE, Preset_o=1 and PresetVal_o=0, so the timer is frozen at 0 and does not toggle or wrap while unused.
  - LOAD, WAIT and DONE behave as without the macro.
  - Reset values of Preset_o and PresetVal_o are unchanged (both 0 during reset).
- Undefined:
  - Preset_o=0 in IDLE.
  - The timer free-runs and wraps, and Zero_i is ignored.

Test Plan:
- Single-request timing: Req_i[0]=1 with Delay 5 at cycle 0 -> Preset_o=1 with PresetVal_o=5 in cycle 1, Done_o[0] pulse in cycle 8 only, Busy_o low again in cycle 9.
- Zero delay: Req_i[1] with Delay 0 -> Done_o[1] in cycle 3; drive Zero_i=1 during IDLE and confirm no spurious Done_o.
- Round-robin: Req_i=4'b1111 with Delay 2 each, held until each Done -> Grant order 0,1,2,3, then Req_i[0] re-asserted is served after 3; no requester is granted twice while another waits.
- Abort: Req_i[2] with Delay 100, drop Req_i[2] at cycle 20 -> IDLE by cycle 21, no Done_o, a pending Req_i[3] is granted next.
- Reset mid-WAIT: assert Reset_n_i=0 during WAIT -> all outputs 0 immediately (async), RR=0; after release, Req_i=4'b1010 grants requester 1 first.
- COUNTER32_SCHED_PARK_EN defined: in IDLE, Preset_o=1 and PresetVal_o=0; in WAIT, Preset_o=0; with the macro undefined, Preset_o=0 in IDLE.

Source files
------------

// File: rtl/counter32_sched_if.sv
// Requester-side bundle of counter32_sched: level requests, packed delays,
// one-hot grant, done pulse and busy flag.
interface counter32_sched_if #(
  parameter int unsigned NumReq = 4
);
  logic [NumReq-1:0]    Req_i;
  logic [32*NumReq-1:0] Delay_i;
  logic [NumReq-1:0]    Grant_o;
  logic [NumReq-1:0]    Done_o;
  logic                 Busy_o;

  modport master (
    output Req_i,
    output Delay_i,
    input  Grant_o,
    input  Done_o,
    input  Busy_o
  );

  modport slave (
    input  Req_i,
    input  Delay_i,
    output Grant_o,
    output Done_o,
    output Busy_o
  );
endinterface

// File: rtl/counter32_sched.sv
// Round-robin scheduler sharing one 32-bit preset/down-count timer between NumReq requesters.
// Define COUNTER32_SCHED_PARK_EN to hold the timer preset to 0 while idle.
module counter32_sched #(
  parameter int unsigned NumReq = 4
) (
  input  logic                Clk_i,
  input  logic                Reset_n_i,
  counter32_sched_if.slave    req_if,
  output logic                Preset_o,
  output logic [31:0]         PresetVal_o,
  input  logic                Zero_i
);

  localparam int unsigned RrW = $clog2(NumReq);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [RrW-1:0]      r_rr, w_rr_d;
  logic [RrW-1:0]      r_g, w_g_d;
  logic [NumReq-1:0]   r_grant, w_grant_d;
  logic [NumReq-1:0]   r_done, w_done_d;
  logic [RrW-1:0]      w_pick;
  logic                w_pick_vld;
  logic                w_req_g;
  logic [31:0]         w_delay_g;

  // First active request at or above the round-robin pointer, wrapping.
  always_comb begin : pick
    int unsigned idx;
    logic [RrW-1:0] idx_n;
    idx        = 0;
    idx_n      = '0;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx   = (32'(r_rr) + i) % NumReq;
      idx_n = RrW'(idx);
      if (!w_pick_vld && req_if.Req_i[idx_n]) begin
        w_pick_vld = 1'b1;
        w_pick     = idx_n;
      end
    end
  end

  assign w_req_g   = req_if.Req_i[r_g];
  assign w_delay_g = req_if.Delay_i[32*r_g +: 32];

  always_comb begin : fsm
    w_state_d = r_state;
    w_rr_d    = r_rr;
    w_g_d     = r_g;
    w_grant_d = r_grant;
    w_done_d  = '0;
    unique case (r_state)
      StIdle: begin
        w_grant_d = '0;
        if (w_pick_vld) begin
          w_state_d = StLoad;
          w_g_d     = w_pick;
          w_grant_d = NumReq'(1) << w_pick;
          if (32'(w_pick) == NumReq - 1) begin
            w_rr_d = '0;
          end else begin
            w_rr_d = w_pick + RrW'(1);
          end
        end
      end
      StLoad: begin
        if (!w_req_g) begin
          w_state_d = StIdle;
          w_grant_d = '0;
        end else begin
          w_state_d = StWait;
        end
      end
      StWait: begin
        // A dropped request aborts the count even if the timer expires this cycle.
        if (!w_req_g) begin
          w_state_d = StIdle;
          w_grant_d = '0;
        end else if (Zero_i) begin
          w_state_d = StDone;
          w_done_d  = r_grant;
        end
      end
      StDone: begin
        w_state_d = StIdle;
        w_grant_d = '0;
      end
      default: begin
        w_state_d = StIdle;
        w_grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      r_state <= StIdle;
      r_rr    <= '0;
      r_g     <= '0;
      r_grant <= '0;
      r_done  <= '0;
    end else begin
      r_state <= w_state_d;
      r_rr    <= w_rr_d;
      r_g     <= w_g_d;
      r_grant <= w_grant_d;
      r_done  <= w_done_d;
    end
  end

  assign req_if.Grant_o = r_grant;
  assign req_if.Done_o  = r_done;
  assign req_if.Busy_o  = (r_state != StIdle);

  always_comb begin : timer_drive
    Preset_o    = 1'b0;
    PresetVal_o = '0;
    if (r_state == StLoad) begin
      Preset_o    = 1'b1;
      PresetVal_o = w_delay_g;
    end
`ifdef COUNTER32_SCHED_PARK_EN
    // Gated by reset so the strobe stays low while reset is asserted.
    else if (r_state == StIdle) begin
      Preset_o = Reset_n_i;
    end
`else
    else begin
      Preset_o = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_counter32_sched.sv
// Directed bench for counter32_sched with a behavioural down-count timer on the timer port.
module tb_counter32_sched;

  localparam int unsigned NumReq = 4;

`ifdef COUNTER32_SCHED_PARK_EN
  localparam logic IdlePreset = 1'b1;
`else
  localparam logic IdlePreset = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        preset;
  logic [31:0] pval;
  logic        zero;
  logic        force_zero;
  logic [31:0] tmr_q;

  int n_checks;
  int n_errors;

  counter32_sched_if #(.NumReq(NumReq)) u_if ();

  counter32_sched #(.NumReq(NumReq)) u_dut (
    .Clk_i       (clk),
    .Reset_n_i   (rst_n),
    .req_if      (u_if),
    .Preset_o    (preset),
    .PresetVal_o (pval),
    .Zero_i      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tmr_q <= '0;
    else if (preset) tmr_q <= pval;
    else             tmr_q <= tmr_q - 32'd1;
  end
  assign zero = force_zero | (tmr_q == 32'd0);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_dly(input int k, input logic [31:0] v);
    u_if.Delay_i[32*k +: 32] = v;
  endtask

  task automatic wait_grant(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (u_if.Grant_o == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("grant%0d", k), 64'(u_if.Grant_o), 64'd1 << k);
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (u_if.Done_o == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done%0d", k), 64'(u_if.Done_o), 64'd1 << k);
    u_if.Req_i[k] = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 64'(u_if.Grant_o), 64'd0);
    chk({tag, "_done"},  64'(u_if.Done_o),  64'd0);
    chk({tag, "_busy"},  64'(u_if.Busy_o),  64'd0);
    chk({tag, "_preset"}, 64'(preset), 64'd0);
    chk({tag, "_pval"},  64'(pval), 64'd0);
  endtask

  initial begin
    logic saw_done;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    force_zero = 1'b0;
    u_if.Req_i   = '0;
    u_if.Delay_i = '0;

    #3;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, delay 5: LOAD in cycle 1, Done in cycle 8, idle in cycle 9.
    set_dly(0, 32'd5);
    u_if.Req_i[0] = 1'b1;
    @(negedge clk);
    chk("c1_preset", 64'(preset), 64'd1);
    chk("c1_pval", 64'(pval), 64'd5);
    chk("c1_grant", 64'(u_if.Grant_o), 64'd1);
    chk("c1_busy", 64'(u_if.Busy_o), 64'd1);
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("single_done_c%0d", c), 64'(u_if.Done_o), (c == 8) ? 64'd1 : 64'd0);
      if (c < 8) chk($sformatf("wait_preset_c%0d", c), 64'(preset), 64'd0);
      if (c == 8) begin
        chk("c8_grant", 64'(u_if.Grant_o), 64'd1);
        u_if.Req_i[0] = 1'b0;
      end
      if (c == 9) begin
        chk("c9_busy", 64'(u_if.Busy_o), 64'd0);
        chk("c9_grant", 64'(u_if.Grant_o), 64'd0);
        chk("c9_idle_preset", 64'(preset), 64'(IdlePreset));
      end
    end

    // Zero delay on requester 1: Done in cycle 3; forced Zero in IDLE must do nothing.
    set_dly(1, 32'd0);
    u_if.Req_i[1] = 1'b1;
    @(negedge clk);
    chk("z_c1_preset", 64'(preset), 64'd1);
    chk("z_c1_pval", 64'(pval), 64'd0);
    @(negedge clk);
    chk("z_c2_done", 64'(u_if.Done_o), 64'd0);
    @(negedge clk);
    chk("z_c3_done", 64'(u_if.Done_o), 64'b0010);
    u_if.Req_i[1] = 1'b0;
    force_zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_zero_done", 64'(u_if.Done_o), 64'd0);
      chk("idle_zero_busy", 64'(u_if.Busy_o), 64'd0);
      chk("idle_preset", 64'(preset), 64'(IdlePreset));
      chk("idle_pval", 64'(pval), 64'd0);
    end
    force_zero = 1'b0;

    // Round robin from a fresh pointer: 0,1,2,3 then re-asserted 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) set_dly(k, 32'd2);
    u_if.Req_i = 4'b1111;
    wait_grant(0);
    wait_done(0);
    wait_grant(1);
    u_if.Req_i[0] = 1'b1;
    wait_done(1);
    wait_grant(2);
    wait_done(2);
    wait_grant(3);
    wait_done(3);
    wait_grant(0);
    wait_done(0);

    // Abort: requester 2 drops in cycle 20, pending requester 3 follows.
    @(negedge clk);
    set_dly(2, 32'd100);
    set_dly(3, 32'd3);
    u_if.Req_i[2] = 1'b1;
    u_if.Req_i[3] = 1'b1;
    saw_done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (u_if.Done_o != '0) saw_done = 1'b1;
      if (c == 1) chk("abort_grant", 64'(u_if.Grant_o), 64'b0100);
      if (c == 20) u_if.Req_i[2] = 1'b0;
    end
    @(negedge clk);
    if (u_if.Done_o != '0) saw_done = 1'b1;
    chk("abort_busy", 64'(u_if.Busy_o), 64'd0);
    chk("abort_grant_clr", 64'(u_if.Grant_o), 64'd0);
    chk("abort_nodone", 64'(saw_done), 64'd0);
    @(negedge clk);
    chk("abort_next_grant", 64'(u_if.Grant_o), 64'b1000);
    wait_done(3);

    // All-ones delay, then asynchronous reset in the middle of WAIT.
    @(negedge clk);
    set_dly(1, 32'hFFFF_FFFF);
    u_if.Req_i[1] = 1'b1;
    @(negedge clk);
    chk("max_pval", 64'(pval), 64'hFFFF_FFFF);
    chk("max_grant", 64'(u_if.Grant_o), 64'b0010);
    repeat (4) @(negedge clk);
    chk("max_wait_busy", 64'(u_if.Busy_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midwait_rst");
    u_if.Req_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    set_dly(1, 32'd2);
    set_dly(3, 32'd1);
    u_if.Req_i = 4'b1010;
    @(negedge clk);
    chk("rst_rr_grant", 64'(u_if.Grant_o), 64'b0010);
    wait_done(1);
    wait_grant(3);
    wait_done(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
